// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: two-stage pipelined posit decoder (sign, scale, fraction, zero/NaR flags)
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   in_valid/ready   input handshake; in_data is the encoded posit
//   out_valid/ready  output handshake; out_* hold the decoded fields
//   out_scale        signed 2^ES*k + e, two's complement
//   out_fraction     bits after the hidden one, MSB-aligned, zero-padded
//   decoded_count    number of completed output transfers (wraps)
module posit_decode_pipe #(
    parameter int NBITS = 32,
    parameter int ES = 2,
    localparam int FBITS = NBITS - 3 - ES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [7:0]       out_scale,
    output logic [FBITS-1:0] out_fraction,
    output logic             out_zero,
    output logic             out_inf,
    output logic [31:0]      decoded_count
);
    localparam int MW = $clog2(NBITS) + 1;

    logic             en;
    logic             sign0, zero0, inf0, run0, done;
    logic [NBITS-2:0] mag0;
    logic [MW-1:0]    len0;
    logic             s1_valid, s1_sign, s1_zero, s1_inf, s1_run;
    logic [MW-1:0]    s1_len;
    logic [NBITS-4:0] s1_mag;
    logic [NBITS-4:0] body;
    logic [7:0]       k, scale2;
    logic             special;

    assign en = ~out_valid | out_ready;
    assign in_ready = en;

    always_comb begin
        sign0 = in_data[NBITS-1];
        zero0 = in_data == '0;
        inf0 = sign0 && in_data[NBITS-2:0] == '0;
        mag0 = sign0 ? ~in_data[NBITS-2:0] + (NBITS-1)'(1) : in_data[NBITS-2:0];
        run0 = mag0[NBITS-2];
        len0 = '0;
        done = 1'b0;
        for (int i = NBITS - 2; i >= 0; i--) begin
            if (mag0[i] != run0) done = 1'b1;
            else if (!done) len0 = len0 + MW'(1);
        end
    end

    // Only the bits below the first two regime bits are kept: shifting them
    // left by m-1 drops the rest of the regime and the terminating bit,
    // leaving exponent then fraction MSB-aligned.
    always_comb begin
        body = s1_mag << (s1_len - MW'(1));
        k = s1_run ? 8'(s1_len) - 8'd1 : 8'd0 - 8'(s1_len);
        scale2 = (k << ES) + 8'(body[NBITS-4 -: ES]);
        special = s1_zero | s1_inf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_inf <= 1'b0;
            s1_run <= 1'b0;
            s1_len <= '0;
            s1_mag <= '0;
            out_valid <= 1'b0;
            out_sign <= 1'b0;
            out_scale <= '0;
            out_fraction <= '0;
            out_zero <= 1'b0;
            out_inf <= 1'b0;
            decoded_count <= '0;
        end else begin
            if (en) begin
                s1_valid <= in_valid;
                s1_sign <= sign0;
                s1_zero <= zero0;
                s1_inf <= inf0;
                s1_run <= run0;
                s1_len <= len0;
                s1_mag <= mag0[NBITS-4:0];
                out_valid <= s1_valid;
                out_sign <= s1_sign;
                out_scale <= special ? '0 : scale2;
                out_fraction <= special ? '0 : body[FBITS-1:0];
                out_zero <= s1_zero;
                out_inf <= s1_inf;
            end
            if (out_valid && out_ready) decoded_count <= decoded_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb_posit_decode_pipe: scoreboard bench for posit_decode_pipe against a bit-walking reference decode
module tb_posit_decode_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic        out_sign, out_zero, out_inf;
    logic [31:0] in_data, decoded_count;
    logic [7:0]  out_scale;
    logic [26:0] out_fraction;
    logic [37:0] cur_f;

    typedef struct {
        logic [37:0] f;
        logic [31:0] d;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          hv = 0;
    logic [37:0] held;
    exp_t        me;
    logic [31:0] dd[12];
    logic [37:0] dx[12];
    bit          acc, have;
    int          sent;
    logic [31:0] cur_d;

    posit_decode_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_scale(out_scale),
        .out_fraction(out_fraction), .out_zero(out_zero), .out_inf(out_inf),
        .decoded_count(decoded_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign cur_f = {out_sign, out_scale, out_fraction, out_zero, out_inf};

    function automatic logic [37:0] mk(logic s, logic [7:0] sc, logic [26:0] f, logic z, logic i);
        return {s, sc, f, z, i};
    endfunction

    // Reference decode: walk the bits of the magnitude one at a time.
    function automatic logic [37:0] model(logic [31:0] x);
        logic [31:0] mag;
        logic [26:0] f;
        logic        s;
        bit          rb;
        int          m, pos, k, e;
        if (x == 32'h0) return mk(1'b0, 8'd0, 27'd0, 1'b1, 1'b0);
        if (x == 32'h8000_0000) return mk(1'b1, 8'd0, 27'd0, 1'b0, 1'b1);
        s = x[31];
        mag = s ? -x : x;
        rb = mag[30];
        m = 0;
        pos = 30;
        while (pos >= 0 && mag[pos] == rb) begin
            m++;
            pos--;
        end
        pos--;
        e = 0;
        for (int i = 0; i < 2; i++) begin
            e = 2 * e + ((pos >= 0) ? int'(mag[pos]) : 0);
            pos--;
        end
        f = '0;
        for (int i = 26; i >= 0; i--) begin
            f[i] = (pos >= 0) ? mag[pos] : 1'b0;
            pos--;
        end
        k = rb ? m - 1 : -m;
        return mk(s, 8'(4 * k + e), f, 1'b0, 1'b0);
    endfunction

    task automatic check(input string n, input logic [63:0] a, input logic [63:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r, input bit use_x,
                        input logic [37:0] x, input bit lat, output bit ok);
        exp_t e;
        in_valid = v;
        in_data = d;
        out_ready = r;
        @(negedge clk);
        ok = v && in_ready && !reset;
        if (ok) begin
            e.f = use_x ? x : model(d);
            e.d = d;
            e.cyc = cyc;
            e.lat = lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string n);
        bit a;
        for (int i = 0; i < 100 && q.size() != 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, a);
        check(n, 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset) hv = 0;
        else begin
            if (hv) check("stall_hold", {25'd0, out_valid, cur_f}, {25'd0, 1'b1, held});
            hv = 0;
            if (out_valid && !out_ready) begin
                hv = 1;
                held = cur_f;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stale_output: got %h while no word expected", cur_f);
                end else begin
                    me = q.pop_front();
                    check($sformatf("decode_%h", me.d), 64'(cur_f), 64'(me.f));
                    if (me.lat) check("latency", 64'(cyc - me.cyc), 64'd2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        dd[0] = 32'h4000_0000; dx[0] = mk(1'b0, 8'h00, 27'h0, 1'b0, 1'b0);
        dd[1] = 32'h4800_0000; dx[1] = mk(1'b0, 8'h01, 27'h0, 1'b0, 1'b0);
        dd[2] = 32'h5000_0000; dx[2] = mk(1'b0, 8'h02, 27'h0, 1'b0, 1'b0);
        dd[3] = 32'h3800_0000; dx[3] = mk(1'b0, 8'hFF, 27'h0, 1'b0, 1'b0);
        dd[4] = 32'hC000_0000; dx[4] = mk(1'b1, 8'h00, 27'h0, 1'b0, 1'b0);
        dd[5] = 32'h7FFF_FFFF; dx[5] = mk(1'b0, 8'd120, 27'h0, 1'b0, 1'b0);
        dd[6] = 32'h0000_0001; dx[6] = mk(1'b0, 8'h88, 27'h0, 1'b0, 1'b0);
        dd[7] = 32'h0000_0000; dx[7] = mk(1'b0, 8'h00, 27'h0, 1'b1, 1'b0);
        dd[8] = 32'h8000_0000; dx[8] = mk(1'b1, 8'h00, 27'h0, 1'b0, 1'b1);
        dd[9] = 32'h4C00_0000; dx[9] = mk(1'b0, 8'h01, 27'h400_0000, 1'b0, 1'b0);
        dd[10] = 32'h4000_0001; dx[10] = mk(1'b0, 8'h00, 27'h1, 1'b0, 1'b0);
        dd[11] = 32'hB400_0000; dx[11] = mk(1'b1, 8'h01, 27'h400_0000, 1'b0, 1'b0);

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(decoded_count), 64'd0);
        check("rst_fields", 64'(cur_f), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            step(1'b1, dd[i], 1'b1, 1'b1, dx[i], 1'b1, acc);
            check("dir_accept", 64'(acc), 64'd1);
        end
        drain("dir_drain");
        check("dir_count", 64'(decoded_count), 64'd12);

        reset = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, acc);
        reset = 1'b0;
        q.delete();

        sent = 0;
        have = 0;
        for (int t = 0; t < 5000 && sent < 100; t++) begin
            if (!have) begin
                cur_d = ($urandom_range(0, 19) == 0) ? 32'h8000_0000 : $urandom();
                have = 1;
            end
            step($urandom_range(0, 3) != 0, cur_d, $urandom_range(0, 2) != 0, 1'b0, '0, 1'b0, acc);
            if (acc) begin
                sent++;
                have = 0;
            end
        end
        check("rand_sent", 64'(sent), 64'd100);
        drain("rand_drain");
        check("rand_count", 64'(decoded_count), 64'd100);

        step(1'b1, $urandom(), 1'b1, 1'b0, '0, 1'b0, acc);
        step(1'b1, $urandom(), 1'b1, 1'b0, '0, 1'b0, acc);
        reset = 1'b1;
        step(1'b1, 32'h4000_0000, 1'b1, 1'b0, '0, 1'b0, acc);
        q.delete();
        check("rst_cycle_accept", 64'(acc), 64'd0);
        check("flight_out_valid", 64'(out_valid), 64'd0);
        check("flight_count", 64'(decoded_count), 64'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, acc);
        check("post_rst_count", 64'(decoded_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
